// File: rtl/maxpool_window_unit.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream.
// Even rows store horizontal pair maxima in a line buffer; odd rows emit the window maxima.
module maxpool_window_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         En,
    input  logic signed [DATA_WIDTH-1:0] Data_In,
    output logic signed [DATA_WIDTH-1:0] Data_Out,
    output logic                         Out_Valid,
    output logic                         Frame_Done
);

    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
    logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                         out_valid_q, out_valid_d;
    logic                         frame_done_q, frame_done_d;

    // Line buffer is deliberately not reset: each entry is rewritten in an even row before use.
    logic signed [DATA_WIDTH-1:0] lb_q [HALF_W];
    logic [LB_AW-1:0]             lb_idx_s;
    logic                         lb_we_s;
    logic signed [DATA_WIDTH-1:0] pair_max_s;
    logic signed [DATA_WIDTH-1:0] lb_rd_s;

    // Next-state: counters, hold register, line-buffer write strobe and pooled output.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we_s      = 1'b0;
        lb_idx_s     = LB_AW'(col_q >> 1);
        lb_rd_s      = lb_q[lb_idx_s];
        pair_max_s   = smax(hold_q, Data_In);
        if (En) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
            if (!col_q[0]) begin
                hold_d = Data_In;
            end else if (!row_q[0]) begin
                lb_we_s = 1'b1;
            end else begin
                data_out_d   = smax(lb_rd_s, pair_max_s);
                out_valid_d  = 1'b1;
                frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end else begin
            out_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line-buffer write of the even-row pair maximum.
    always_ff @(posedge Clk) begin
        if (lb_we_s && !Rst) begin
            lb_q[lb_idx_s] <= pair_max_s;
        end
    end

    assign Data_Out   = data_out_q;
    assign Out_Valid  = out_valid_q;
    assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_maxpool_window_unit.sv
// Directed bench for maxpool_window_unit (4x4 frames, 16-bit pixels) with an output scoreboard.
module tb_maxpool_window_unit;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic [15:0] Data_In;
    logic [15:0] Data_Out;
    logic        Out_Valid;
    logic        Frame_Done;

    maxpool_window_unit #(
        .DATA_WIDTH(16),
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .Data_In   (Data_In),
        .Data_Out  (Data_Out),
        .Out_Valid (Out_Valid),
        .Frame_Done(Frame_Done)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
        bit          done;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_seen = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] last_out = 16'h0000;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares the registered outputs produced by the most recent rising edge.
    task automatic check_outputs();
        exp_t e;
        bit   overdue;
        overdue = (sb_q.size() > 0) && (cyc > sb_q[0].due);
        chk("missed_output", {15'd0, overdue}, 16'd0);
        chk("valid_known", {15'd0, $isunknown(Out_Valid)}, 16'd0);
        chk("no_back_to_back_valid", {15'd0, Out_Valid & prev_valid}, 16'd0);
        if (Rst === 1'b1) begin
            last_out = 16'h0000;
            chk("reset_out_valid", {15'd0, Out_Valid}, 16'd0);
            chk("reset_frame_done", {15'd0, Frame_Done}, 16'd0);
            chk("reset_data_out", Data_Out, 16'h0000);
        end else if (Out_Valid === 1'b1) begin
            chk("unexpected_output", {15'd0, sb_q.size() == 0}, 16'd0);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("data_out", Data_Out, e.val);
                chk("frame_done", {15'd0, Frame_Done}, {15'd0, e.done});
                chk("latency", 16'(cyc), 16'(e.due));
                last_out = e.val;
            end
        end else begin
            chk("idle_frame_done", {15'd0, Frame_Done}, 16'd0);
            chk("idle_data_hold", Data_Out, last_out);
        end
        if (Frame_Done === 1'b1) done_seen++;
        prev_valid = Out_Valid;
    endtask

    task automatic step(input logic en, input logic rst, input logic [15:0] px,
                        input bit push, input logic [15:0] ev, input bit ed);
        exp_t e;
        @(negedge Clk);
        check_outputs();
        En      = en;
        Rst     = rst;
        Data_In = px;
        if (push) begin
            e.due  = cyc + 1;
            e.val  = ev;
            e.done = ed;
            sb_q.push_back(e);
        end
    endtask

    // Window-completing pixels of a 4x4 frame are raster indices 5, 7, 13 and 15.
    task automatic ramp(input int base, input bit stall);
        for (int i = 0; i < 16; i++) begin
            bit comp;
            comp = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            step(1'b1, 1'b0, 16'(base + i), comp, 16'(base + i), i == 15);
            if (stall) step(1'b0, 1'b0, 16'hDEAD, 1'b0, 16'h0000, 1'b0);
        end
    endtask

    initial begin
        Rst     = 1'b1;
        En      = 1'b1;
        Data_In = 16'h7FFF;
        @(negedge Clk);
        check_outputs();
        step(1'b1, 1'b1, 16'h7FFF, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h7FFF, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0);

        ramp(0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] px;
            logic [15:0] ev;
            px = (i == 4) ? 16'hFFFF : (i == 10) ? 16'h8000 : 16'hFFFD;
            ev = (i == 5) ? 16'hFFFF : 16'hFFFD;
            step(1'b1, 1'b0, px, (i == 5) || (i == 7) || (i == 13) || (i == 15), ev, i == 15);
        end

        ramp(0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'(i), i == 5, 16'd5, 1'b0);
        end
        step(1'b1, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0);
        ramp(100, 1'b0);

        ramp(0, 1'b0);
        ramp(16, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'h5A5A, 1'b0, 16'h0000, 1'b0);
        end
        chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);
        chk("frame_done_count", 16'(done_seen), 16'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
